// File: rtl/despachador_salida.sv
// despachador_salida: round-robin drain of the four blue FIFOs onto a single
// valid/ready output link, each word tagged with the FIFO it came from.
// Optional feature macro: STATS_EN (per-port handshake counters with a
// request/response read port). Without it cnt_data/cnt_valid are tied low.
//
// state | meaning
// ARB   | idle; pop the round-robin grant when enabled and any FIFO has data
// LOAD  | popped word arrives on data_in_p[sel]; capture it into the output register
// SEND  | word presented; hold until handshake, optionally popping the next grant
module despachador_salida #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] data_in_p0,
  input  logic [DATA_W-1:0] data_in_p1,
  input  logic [DATA_W-1:0] data_in_p2,
  input  logic [DATA_W-1:0] data_in_p3,
  output logic [3:0]        pop,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        dest_out,
  output logic              valid_out,
  input  logic              ready_in,
  input  logic              req,
  input  logic [1:0]        idx,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              cnt_valid
);

  typedef enum logic [1:0] {ST_ARB, ST_LOAD, ST_SEND} state_t;

  state_t            state_q;
  logic [1:0]        sel_q;
  logic [1:0]        rr_last_q;
  logic [DATA_W-1:0] data_out_q;
  logic [1:0]        dest_out_q;
  logic              valid_out_q;

  logic [1:0]        grant;
  logic [1:0]        cand;
  logic              found;
  logic              pop_ok;
  logic              do_pop;
  logic [DATA_W-1:0] data_sel;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    grant = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_last_q + k[1:0];
      if (!found && !fifo_empty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // A pop is decided combinationally so the next word can be fetched in the
  // same cycle as the handshake; held low while reset is asserted.
  assign pop_ok = (state_q == ST_ARB) | ((state_q == ST_SEND) & ready_in);
  assign do_pop = ~reset & Enable & found & pop_ok;
  assign pop    = do_pop ? (4'b0001 << grant) : 4'b0000;

  // Read-data mux for the port popped in the previous cycle.
  always_comb begin
    data_sel = data_in_p0;
    case (sel_q)
      2'd0:    data_sel = data_in_p0;
      2'd1:    data_sel = data_in_p1;
      2'd2:    data_sel = data_in_p2;
      default: data_sel = data_in_p3;
    endcase
  end

  // Arbitration / load / send sequencing with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ARB;
      sel_q       <= 2'd0;
      rr_last_q   <= 2'd3;
      data_out_q  <= '0;
      dest_out_q  <= 2'd0;
      valid_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (do_pop) begin
            sel_q     <= grant;
            rr_last_q <= grant;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_out_q  <= data_sel;
          dest_out_q  <= sel_q;
          valid_out_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (ready_in) begin
            valid_out_q <= 1'b0;
            if (do_pop) begin
              sel_q     <= grant;
              rr_last_q <= grant;
              state_q   <= ST_LOAD;
            end else begin
              state_q <= ST_ARB;
            end
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign dest_out  = dest_out_q;
  assign valid_out = valid_out_q;

`ifdef STATS_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_data_q;
  logic             cnt_valid_q;

  // Per-port handshake counters (wrapping) and one-cycle read response.
  // A read in the handshake cycle returns the value before the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
    end else begin
      if (valid_out_q && ready_in) begin
        cnt_q[dest_out_q] <= cnt_q[dest_out_q] + CNT_W'(1);
      end
      if (req) begin
        cnt_data_q  <= cnt_q[idx];
        cnt_valid_q <= 1'b1;
      end else begin
        cnt_valid_q <= 1'b0;
      end
    end
  end

  assign cnt_data  = cnt_data_q;
  assign cnt_valid = cnt_valid_q;
`else
  logic unused_stats;
  assign unused_stats = ^{req, idx};
  assign cnt_data     = '0;
  assign cnt_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_despachador_salida.sv
// Testbench for despachador_salida: queue-based FIFO models upstream, a
// round-robin reference over the queued words, directed scenarios and a
// randomized drain phase.
module tb_despachador_salida;
  localparam int DATA_W = 12;
  localparam int CNT_W  = 5;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              reset, Enable, ready_in, req;
  logic [1:0]        idx;
  logic [3:0]        fifo_empty, pop;
  logic [DATA_W-1:0] din [4];
  logic [DATA_W-1:0] data_out;
  logic [1:0]        dest_out;
  logic              valid_out, cnt_valid;
  logic [CNT_W-1:0]  cnt_data;

  despachador_salida #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Enable(Enable), .fifo_empty(fifo_empty),
    .data_in_p0(din[0]), .data_in_p1(din[1]), .data_in_p2(din[2]), .data_in_p3(din[3]),
    .pop(pop), .data_out(data_out), .dest_out(dest_out), .valid_out(valid_out),
    .ready_in(ready_in), .req(req), .idx(idx), .cnt_data(cnt_data), .cnt_valid(cnt_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Upstream FIFOs: read data appears the cycle after a pop.
  logic [DATA_W-1:0] mem [4][DEPTH];
  int wr_ptr [4] = '{0, 0, 0, 0};
  int rd_ptr [4] = '{0, 0, 0, 0};

  always_comb begin
    for (int n = 0; n < 4; n++) fifo_empty[n] = (rd_ptr[n] == wr_ptr[n]);
  end

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (pop[n] && rd_ptr[n] != wr_ptr[n]) begin
        din[n]    <= mem[n][rd_ptr[n] % DEPTH];
        rd_ptr[n] <= rd_ptr[n] + 1;
      end
    end
  end

  // Reference: words still owed per port, served round-robin after rr_m.
  logic [DATA_W-1:0] exp_q [4][$];
  int rr_m = 3;
  int cnt_m [4] = '{0, 0, 0, 0};

  function automatic int next_port();
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (rr_m + k) % 4;
      if (exp_q[c].size() > 0) return c;
    end
    return -1;
  endfunction

  function automatic int remaining();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction

  task automatic push(input int n, input logic [DATA_W-1:0] v);
    mem[n][wr_ptr[n] % DEPTH] = v;
    wr_ptr[n] = wr_ptr[n] + 1;
    exp_q[n].push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int i = 0;
    while (remaining() > 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    check(tag, 32'(remaining()), 0);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int i = 0;
    while (!valid_out && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(valid_out), 1);
  endtask

  task automatic model_reset();
    rr_m = 3;
    for (int n = 0; n < 4; n++) cnt_m[n] = 0;
  endtask

  // Monitor: protocol checks every cycle, scoreboard on every presented word.
  int  cyc = 0;
  int  n_hs = 0;
  int  n_pops = 0;
  int  last_pop_cyc = -1;
  int  last_hs_cyc = -1;
  bit  tput_chk = 1'b0;
  int  dlog [$];
  logic [DATA_W-1:0] wlog [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int p;
    if (!reset) begin
      check("pop_onehot", 32'($onehot0(pop)), 1);
      check("pop_on_empty", 32'(pop & fifo_empty), 0);
      if (!tput_chk) begin
        last_pop_cyc = -1;
        last_hs_cyc  = -1;
      end
      if (pop != 4'd0) begin
        n_pops++;
        if (tput_chk && last_pop_cyc >= 0) check("pop_gap", 32'(cyc - last_pop_cyc), 2);
        last_pop_cyc = cyc;
      end
      if (valid_out) begin
        p = next_port();
        if (p < 0) begin
          check("unexpected_word", 32'(valid_out), 0);
        end else begin
          check("word_data", 32'(data_out), 32'(exp_q[p][0]));
          check("word_dest", 32'(dest_out), 32'(p));
          if (!ready_in) begin
            check("stall_pop", 32'(pop), 0);
          end else begin
            void'(exp_q[p].pop_front());
            rr_m = p;
            cnt_m[p] = (cnt_m[p] + 1) % (1 << CNT_W);
            n_hs++;
            dlog.push_back(int'(dest_out));
            wlog.push_back(data_out);
            if (tput_chk && last_hs_cyc >= 0) check("hs_gap", 32'(cyc - last_hs_cyc), 2);
            last_hs_cyc = cyc;
          end
        end
      end
`ifndef STATS_EN
      check("cnt_tied", 32'({cnt_valid, cnt_data}), 0);
`endif
    end
  end

  int t3_exp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int pops0, p;
    logic [DATA_W-1:0] wa, wc;
`ifdef STATS_EN
    int pre;
`endif
    reset = 1'b1; Enable = 1'b0; ready_in = 1'b0; req = 1'b0; idx = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_dest", 32'(dest_out), 0);
    check("rst_pop", 32'(pop), 0);
    check("rst_cnt_valid", 32'(cnt_valid), 0);
    reset = 1'b0;

    // All four ports loaded: dest sequence 0,1,2,3,0,1 at full rate.
    push(0, DATA_W'($urandom)); push(0, DATA_W'($urandom));
    push(1, DATA_W'($urandom)); push(1, DATA_W'($urandom));
    push(2, DATA_W'($urandom)); push(3, DATA_W'($urandom));
    dlog.delete();
    tput_chk = 1'b1; Enable = 1'b1; ready_in = 1'b1;
    wait_drain(40, "t3_timeout");
    check("t3_count", 32'(dlog.size()), 6);
    for (int k = 0; k < 6 && k < dlog.size(); k++) check("t3_dest", 32'(dlog[k]), 32'(t3_exp[k]));
    tick();
    tput_chk = 1'b0;

    // Single port p2 with three words.
    Enable = 1'b0; tick();
    push(2, 12'h2A1); push(2, 12'h2A2); push(2, 12'h2A3);
    dlog.delete(); wlog.delete();
    pops0 = n_pops;
    tput_chk = 1'b1; Enable = 1'b1;
    wait_drain(30, "t2_timeout");
    repeat (4) tick();
    check("t2_pops", 32'(n_pops - pops0), 3);
    check("t2_count", 32'(wlog.size()), 3);
    if (wlog.size() == 3) begin
      check("t2_w0", 32'(wlog[0]), 32'h2A1);
      check("t2_w1", 32'(wlog[1]), 32'h2A2);
      check("t2_w2", 32'(wlog[2]), 32'h2A3);
      check("t2_dest", 32'(dlog[2]), 2);
    end
    tput_chk = 1'b0;

    // Backpressure: held word stable for five cycles, then handoff + same-cycle pop.
    Enable = 1'b0; ready_in = 1'b0;
    wa = DATA_W'($urandom);
    push(0, wa); push(1, DATA_W'($urandom));
    tick(); Enable = 1'b1;
    wait_valid(10, "t4_valid");
    repeat (5) begin
      tick();
      check("t4_hold_data", 32'(data_out), 32'(wa));
      check("t4_hold_dest", 32'(dest_out), 0);
      check("t4_hold_pop", 32'(pop), 0);
    end
    ready_in = 1'b1;
    #1;
    check("t4_next_pop", 32'(pop), 32'h2);
    wait_drain(20, "t4_timeout");

    // Enable dropped during LOAD: word still delivered, no further pops.
    Enable = 1'b0; tick();
    wc = DATA_W'($urandom);
    push(3, wc); push(0, DATA_W'($urandom));
    Enable = 1'b1;
    #1;
    check("t5_first_pop", 32'(pop), 32'h8);
    tick();
    Enable = 1'b0;
    tick();
    check("t5_valid", 32'(valid_out), 1);
    check("t5_data", 32'(data_out), 32'(wc));
    check("t5_no_pop_hs", 32'(pop), 0);
    repeat (5) begin
      tick();
      check("t5_idle_valid", 32'(valid_out), 0);
      check("t5_idle_pop", 32'(pop), 0);
    end
    Enable = 1'b1;
    #1;
    check("t5_resume_pop", 32'(pop), 32'h1);
    wait_drain(20, "t5_timeout");

    // Reset mid-SEND drops the held word; first grant afterwards is p0.
    Enable = 1'b0; ready_in = 1'b0; tick();
    for (int n = 0; n < 4; n++) begin
      push(n, DATA_W'($urandom));
      push(n, DATA_W'($urandom));
    end
    Enable = 1'b1;
    wait_valid(10, "t1_valid");
    repeat (2) tick();
    #1;
    reset = 1'b1;
    #1;
    check("t1_pop", 32'(pop), 0);
    check("t1_valid", 32'(valid_out), 0);
    check("t1_data", 32'(data_out), 0);
    check("t1_dest", 32'(dest_out), 0);
    p = next_port();
    if (p >= 0) void'(exp_q[p].pop_front());
    model_reset();
    dlog.delete();
    repeat (2) tick();
    reset = 1'b0; ready_in = 1'b1;
    #1;
    check("t1_first_grant", 32'(pop), 32'h1);
    wait_drain(60, "t1_timeout");
    if (dlog.size() > 0) check("t1_first_dest", 32'(dlog[0]), 0);

    // Randomized rounds with random backpressure, Enable and stat reads.
    for (int r = 0; r < 6; r++) begin
      int i;
      Enable = 1'b0; req = 1'b0; tick();
      for (int n = 0; n < 4; n++) begin
        int cnt = $urandom_range(0, 6);
        for (int j = 0; j < cnt; j++) push(n, DATA_W'($urandom));
      end
      i = 0;
      while (remaining() > 0 && i < 300) begin
        ready_in = ($urandom_range(0, 3) != 0);
        Enable   = ($urandom_range(0, 4) != 0);
        req      = 1'($urandom);
        idx      = 2'($urandom);
        tick();
        i++;
      end
      check("rand_timeout", 32'(remaining()), 0);
    end
    req = 1'b0; ready_in = 1'b1; Enable = 1'b0;
    repeat (2) tick();

`ifdef STATS_EN
    for (int n = 0; n < 4; n++) begin
      req = 1'b1; idx = 2'(n);
      tick();
      check("st_valid", 32'(cnt_valid), 1);
      check("st_data", 32'(cnt_data), 32'(cnt_m[n]));
    end
    req = 1'b0;
    tick();
    check("st_idle_valid", 32'(cnt_valid), 0);
    check("st_hold_data", 32'(cnt_data), 32'(cnt_m[3]));

    // Read in the handshake cycle returns the pre-increment value.
    ready_in = 1'b0; push(2, DATA_W'($urandom));
    Enable = 1'b1;
    wait_valid(10, "st_pre_valid");
    Enable = 1'b0;
    pre = cnt_m[2];
    ready_in = 1'b1; req = 1'b1; idx = 2'd2;
    tick();
    check("st_pre_inc", 32'(cnt_data), 32'(pre));
    tick();
    check("st_post_inc", 32'(cnt_data), 32'((pre + 1) % (1 << CNT_W)));
    req = 1'b0;
    tick();

    // 33 words from p1 after a fresh reset: counter wraps to 1.
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    for (int j = 0; j < 33; j++) push(1, DATA_W'($urandom));
    Enable = 1'b1; ready_in = 1'b1;
    wait_drain(200, "t6_timeout");
    Enable = 1'b0;
    tick();
    req = 1'b1; idx = 2'd1;
    tick();
    check("t6_valid", 32'(cnt_valid), 1);
    check("t6_p1_wrap", 32'(cnt_data), 1);
    idx = 2'd0;
    tick();
    check("t6_p0", 32'(cnt_data), 0);
    req = 1'b0;
    tick();
    check("t6_idle", 32'(cnt_valid), 0);
`else
    req = 1'b1; idx = 2'd1;
    tick();
    check("nostats_valid", 32'(cnt_valid), 0);
    check("nostats_data", 32'(cnt_data), 0);
    req = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, required finish before %0t", $time);
    $fatal(1);
  end

endmodule
